// File: rtl/fifo_burst_reader_pkg.sv
// Shared types for the FIFO burst reader: FSM state encoding and count-width helper.
package fifo_burst_reader_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StRead  = 2'd1,
        StDrain = 2'd2
    } state_e;

    // FIFO occupancy needs one bit more than the address to represent "full".
    function automatic int unsigned count_width(input int unsigned m);
        return m + 1;
    endfunction

endpackage

// File: rtl/fifo_burst_reader_skid_buffer2.sv
// Two-entry skid buffer with valid/ready on both sides; holds {last, data} words.
module skid_buffer2 #(
    parameter int unsigned Width = 9
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [Width-1:0] in_data_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [Width-1:0] out_data_o,
    output logic [1:0]       count_o
);

    logic [Width-1:0] mem_q [2];
    logic             wr_ptr_q;
    logic             rd_ptr_q;
    logic [1:0]       count_q;
    logic             push;
    logic             pop;

    assign out_valid_o = (count_q != 2'd0);
    // A full buffer still accepts when the head leaves in the same cycle.
    assign in_ready_o  = (count_q != 2'd2) || out_ready_i;
    assign push        = in_valid_i && in_ready_o;
    assign pop         = out_valid_o && out_ready_i;
    assign out_data_o  = mem_q[rd_ptr_q];
    assign count_o     = count_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= in_data_i;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q <= count_q + 2'(push) - 2'(pop);
        end
    end

endmodule

// File: rtl/fifo_burst_reader.sv
// Read-side master for the dual-clock FIFO: pulls fixed-length (or flushed short) bursts
// and presents them as a valid/ready stream framed by out_last.
module fifo_burst_reader
    import fifo_burst_reader_pkg::*;
#(
    parameter int unsigned Nb        = 8,
    parameter int unsigned M         = 2,
    parameter int unsigned BURST_LEN = 4
) (
    input  logic          clk,
    input  logic          reset,
    output logic          fifo_rd_ready,
    input  logic [Nb-1:0] fifo_rd_data,
    input  logic [M:0]    fifo_rd_count,
    input  logic          flush,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [Nb-1:0] out_data,
    output logic          out_last,
    output logic          busy
);

    localparam int unsigned CntW = count_width(M);
    localparam logic [CntW-1:0] BurstLenC = CntW'(BURST_LEN);

    if (BURST_LEN < 1 || BURST_LEN > (1 << M)) begin : g_bad_burst_len
        $error("fifo_burst_reader: BURST_LEN must be within 1..2^M");
    end

    state_e          state_q, state_d;
    logic [CntW-1:0] len_q, len_d;
    logic [CntW-1:0] issued_q, issued_d;
    logic [CntW-1:0] issued_inc;
    logic            inflight_q;
    logic            inflight_last_q;
    logic            strobe;
    logic            room;
    logic [2:0]      occ;

    logic [1:0]      buf_count;
    logic            buf_in_ready;
    logic            buf_in_valid;
    logic            buf_out_valid;
    logic [Nb:0]     buf_out_data;
    logic            pop;

    assign pop        = buf_out_valid && out_ready;
    assign issued_inc = issued_q + CntW'(1);
    // Slots claimed once this cycle's pop leaves; a new strobe needs one free slot.
    assign occ        = 3'(buf_count) + 3'(inflight_q) - 3'(pop);
    assign room       = (occ < 3'd2);

    always_comb begin
        state_d  = state_q;
        len_d    = len_q;
        issued_d = issued_q;
        strobe   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (fifo_rd_count >= BurstLenC) begin
                    len_d    = BurstLenC;
                    issued_d = '0;
                    state_d  = StRead;
                end else if (flush && (fifo_rd_count != '0)) begin
                    len_d    = fifo_rd_count;
                    issued_d = '0;
                    state_d  = StRead;
                end
            end
            StRead: begin
                if ((fifo_rd_count != '0) && room) begin
                    strobe   = 1'b1;
                    issued_d = issued_inc;
                    if (issued_inc == len_q) begin
                        state_d = StDrain;
                    end
                end
            end
            StDrain: begin
                if (pop && buf_out_data[Nb]) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign fifo_rd_ready = strobe && !reset;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= StIdle;
            len_q           <= '0;
            issued_q        <= '0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            len_q           <= len_d;
            issued_q        <= issued_d;
            inflight_q      <= strobe;
            inflight_last_q <= strobe && (issued_inc == len_q);
        end
    end

    // The strobe rule keeps a slot free for every read in flight, so ready is always high here.
    assign buf_in_valid = inflight_q && buf_in_ready;

    skid_buffer2 #(
        .Width (Nb + 1)
    ) u_skid (
        .clk         (clk),
        .reset       (reset),
        .in_valid_i  (buf_in_valid),
        .in_ready_o  (buf_in_ready),
        .in_data_i   ({inflight_last_q, fifo_rd_data}),
        .out_valid_o (buf_out_valid),
        .out_ready_i (out_ready),
        .out_data_o  (buf_out_data),
        .count_o     (buf_count)
    );

    assign out_valid = buf_out_valid;
    assign out_data  = buf_out_data[Nb-1:0];
    assign out_last  = buf_out_valid && buf_out_data[Nb];
    assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Bench for fifo_burst_reader: emulated FIFO, expected-word queue and randomized backpressure.
module tb_fifo_burst_reader;

    localparam int unsigned Nb       = 8;
    localparam int unsigned M        = 2;
    localparam int unsigned BurstLen = 4;
    localparam int unsigned Depth    = 4;
    localparam int unsigned CntW     = M + 1;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          fifo_rd_ready;
    logic [Nb-1:0] fifo_rd_data = '0;
    logic [M:0]    fifo_rd_count = '0;
    logic          flush = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [Nb-1:0] out_data;
    logic          out_last;
    logic          busy;

    always #5 clk = ~clk;

    fifo_burst_reader #(
        .Nb        (Nb),
        .M         (M),
        .BURST_LEN (BurstLen)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .fifo_rd_ready (fifo_rd_ready),
        .fifo_rd_data  (fifo_rd_data),
        .fifo_rd_count (fifo_rd_count),
        .flush         (flush),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_data      (out_data),
        .out_last      (out_last),
        .busy          (busy)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Words waiting on the write side, words inside the FIFO, and the expected output stream.
    logic [Nb-1:0] src_q [$];
    logic [Nb-1:0] fifo_q [$];
    logic [Nb:0]   exp_q [$];

    int cyc = 0;
    int sc, ac, vc;
    int first_strobe, last_strobe, first_acc, last_acc, busy_fall;
    int held = 0;
    bit inflight = 1'b0;
    bit rd_s;
    bit busy_prev = 1'b0;
    bit acc;
    logic [Nb:0] e;

    // Environment: checks the output stream at the falling edge, then updates the FIFO model.
    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            rd_s = fifo_rd_ready;
            if (reset) begin
                held     = 0;
                inflight = 1'b0;
            end else begin
                acc = out_valid && out_ready;
                check_eq("valid_vs_model", 32'(out_valid), 32'(held != 0));
                if (fifo_rd_ready) begin
                    check_eq("strobe_nonempty", 32'(fifo_rd_count != 0), 1);
                    check_eq("strobe_room", 32'((held + int'(inflight) - int'(acc)) < 2), 1);
                    if (sc == 0) first_strobe = cyc;
                    last_strobe = cyc;
                    sc++;
                end
                if (out_valid) vc++;
                if (acc) begin
                    if (exp_q.size() == 0) begin
                        check_eq("unexpected_word", 32'(out_data), 32'hFFFF_FFFF);
                    end else begin
                        e = exp_q.pop_front();
                        check_eq("out_data", 32'(out_data), 32'(e[Nb-1:0]));
                        check_eq("out_last", 32'(out_last), 32'(e[Nb]));
                    end
                    if (ac == 0) first_acc = cyc;
                    last_acc = cyc;
                    ac++;
                end
                if (busy_prev && !busy) busy_fall = cyc;
                held     = held + int'(inflight) - int'(acc);
                inflight = fifo_rd_ready;
            end
            busy_prev = busy;
            @(posedge clk);
            #1;
            if (rd_s && fifo_q.size() > 0) fifo_rd_data = fifo_q.pop_front();
            while (fifo_q.size() < Depth && src_q.size() > 0) fifo_q.push_back(src_q.pop_front());
            fifo_rd_count = CntW'(fifo_q.size());
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic clear_win();
        sc = 0; ac = 0; vc = 0;
        first_strobe = -1; last_strobe = -1;
        first_acc = -1; last_acc = -1; busy_fall = -1;
    endtask

    task automatic push_word(input logic [Nb-1:0] d, input logic last);
        src_q.push_back(d);
        exp_q.push_back({last, d});
    endtask

    task automatic wait_done(input int budget, input string tag);
        int i = 0;
        while ((exp_q.size() != 0 || busy) && i < budget) begin
            step(1);
            i++;
        end
        check_eq(tag, 32'(exp_q.size() == 0 && !busy), 1);
    endtask

    logic pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    logic [Nb-1:0] tmp_q [$];
    int n, extra, words;

    initial begin
        clear_win();
        repeat (3) @(posedge clk);
        #2 reset = 1'b0;
        @(negedge clk);
        check_eq("rst_rd_ready", 32'(fifo_rd_ready), 0);
        check_eq("rst_out_valid", 32'(out_valid), 0);
        check_eq("rst_out_data", 32'(out_data), 0);
        check_eq("rst_out_last", 32'(out_last), 0);
        check_eq("rst_busy", 32'(busy), 0);

        // Full burst with preloaded FIFO and no backpressure.
        step(1);
        clear_win();
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) push_word(Nb'(8'h11 + i), i == 3);
        wait_done(40, "full_done");
        step(2);
        check_eq("full_strobes", 32'(sc), 4);
        check_eq("full_strobe_span", 32'(last_strobe - first_strobe), 3);
        check_eq("full_accepts", 32'(ac), 4);
        check_eq("full_acc_span", 32'(last_acc - first_acc), 3);
        check_eq("full_busy_drop", 32'(busy_fall), 32'(last_acc + 1));

        // Below threshold, then flush releases a short burst.
        clear_win();
        for (int i = 0; i < 3; i++) push_word(Nb'(8'h21 + i), i == 2);
        step(50);
        check_eq("below_no_strobe", 32'(sc), 0);
        check_eq("below_idle", 32'(busy), 0);
        flush = 1'b1;
        wait_done(40, "flush_done");
        flush = 1'b0;
        check_eq("flush_accepts", 32'(ac), 3);
        step(2);
        check_eq("flush_idle", 32'(busy), 0);

        // Backpressure pattern 1,0,0,1 over two bursts.
        clear_win();
        for (int i = 0; i < 8; i++) push_word(Nb'(8'h31 + i), (i % 4) == 3);
        for (int i = 0; i < 200 && (exp_q.size() != 0 || busy); i++) begin
            out_ready = pat[i % 4];
            step(1);
        end
        out_ready = 1'b1;
        wait_done(20, "bp_done");
        check_eq("bp_accepts", 32'(ac), 8);

        // Long stall: exactly two reads, then nothing until the sink resumes.
        clear_win();
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) push_word(Nb'(8'h41 + i), i == 3);
        step(30);
        check_eq("stall_strobes", 32'(sc), 2);
        check_eq("stall_valid", 32'(out_valid), 1);
        out_ready = 1'b1;
        wait_done(40, "stall_done");

        // Empty FIFO with flush held.
        clear_win();
        flush = 1'b1;
        step(30);
        check_eq("empty_strobes", 32'(sc), 0);
        check_eq("empty_valid", 32'(vc), 0);
        flush = 1'b0;

        // Reset after two words of a burst are accepted.
        clear_win();
        for (int i = 0; i < 4; i++) push_word(Nb'(8'h51 + i), i == 3);
        for (int i = 0; i < 50 && ac < 2; i++) step(1);
        check_eq("rst_reach_two", 32'(ac >= 2), 1);
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        @(negedge clk);
        check_eq("mid_rst_rd_ready", 32'(fifo_rd_ready), 0);
        check_eq("mid_rst_valid", 32'(out_valid), 0);
        check_eq("mid_rst_data", 32'(out_data), 0);
        check_eq("mid_rst_last", 32'(out_last), 0);
        check_eq("mid_rst_busy", 32'(busy), 0);
        @(posedge clk);
        #2;
        // Words still in the FIFO survive; bursts restart from the new head.
        tmp_q = {fifo_q, src_q};
        exp_q.delete();
        n = 0;
        foreach (tmp_q[k]) begin
            n++;
            exp_q.push_back({(n % BurstLen) == 0, tmp_q[k]});
        end
        extra = 4 + ((BurstLen - (n % BurstLen)) % BurstLen);
        for (int i = 0; i < extra; i++) begin
            n++;
            push_word(Nb'(8'h61 + i), (n % BurstLen) == 0);
        end
        clear_win();
        wait_done(80, "rst_refill_done");
        check_eq("rst_refill_accepts", 32'(ac), 32'(n));

        // Back-to-back bursts.
        clear_win();
        for (int i = 0; i < 8; i++) push_word(Nb'(8'h71 + i), (i % 4) == 3);
        wait_done(60, "b2b_done");
        check_eq("b2b_accepts", 32'(ac), 8);

        // Randomized data and backpressure.
        for (int r = 0; r < 6; r++) begin
            clear_win();
            words = 4 * $urandom_range(1, 3);
            for (int i = 0; i < words; i++) push_word(Nb'($urandom), (i % 4) == 3);
            for (int i = 0; i < 400 && (exp_q.size() != 0 || busy); i++) begin
                out_ready = ($urandom_range(0, 3) != 0);
                step(1);
            end
            out_ready = 1'b1;
            wait_done(40, "rand_done");
            check_eq("rand_accepts", 32'(ac), 32'(words));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
